// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_pkg : scan state encoding and active-low segment codes
// Revision 1.0
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] c_SEG_OFF = 7'h7F;
  // Level of a single anode when it is switched off (anodes are active low)
  localparam logic       c_AN_OFF  = 1'b1;

  // Cathode codes {g,f,e,d,c,b,a}, active low, indexed by nibble value
  localparam logic [6:0] c_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_scan_if : display value load bus and live display controls
// Revision 1.0
// ---------------------------------------------------------------------------
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  import seven_seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] disp_data;
  logic                    disp_load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lzb_en;

  modport master (
    output disp_data,
    output disp_load,
    output digit_en,
    output lzb_en
  );

  modport slave (
    input  disp_data,
    input  disp_load,
    input  digit_en,
    input  lzb_en
  );

endinterface
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_to_seg7 : combinational nibble to active-low seven-segment code
// Revision 1.0
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = c_SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_scan : time-multiplexed multi-digit seven-segment scanner with
//                  frame-aligned double-buffered display value
// Revision 1.0
// ---------------------------------------------------------------------------
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV   = 3,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_if.slave       bus,
  output logic [NUM_DIGITS-1:0] o_seven_seg_an,
  output logic [6:0]            o_seven_seg_cat,
  output logic                  o_frame_done
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0]      c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      c_CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ALL_OFF = {NUM_DIGITS{c_AN_OFF}};

  scan_state_t            r_state;
  scan_state_t            w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [DATA_W-1:0]      r_disp;
  logic [DATA_W-1:0]      r_shadow;
  logic                   r_pending;
  logic [NUM_DIGITS-1:0]  r_an;
  logic [NUM_DIGITS-1:0]  w_an_nxt;
  logic [6:0]             r_cat;
  logic [6:0]             w_cat_nxt;
  logic                   r_frame_done;
  logic                   w_frame_end;
  logic [NUM_DIGITS-1:0]  w_upper_zero;
  logic                   w_visible;
  logic [3:0]             w_nibble;
  logic [6:0]             w_seg;

  // w_upper_zero[i] is set when nibbles i..NUM_DIGITS-1 of the shown value are all zero
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_upper_zero
      assign w_upper_zero[i] = ~|r_disp[DATA_W-1:4*i];
    end
  endgenerate

  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble = r_disp[4*i +: 4];
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0"
  assign w_visible = bus.digit_en[r_idx] &&
                     !(bus.lzb_en && (r_idx != '0) && w_upper_zero[r_idx]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_frame_end = 1'b0;
    w_an_nxt    = c_AN_ALL_OFF;
    w_cat_nxt   = c_SEG_OFF;
    case (r_state)
      ST_BLANK: begin
        w_state_nxt = ST_DRIVE;
        w_cnt_nxt   = '0;
      end
      ST_DRIVE: begin
        if (w_visible) begin
          w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
          w_cat_nxt = w_seg;
        end
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_frame_end = (r_idx == c_IDX_LAST);
          w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_an         <= c_AN_ALL_OFF;
      r_cat        <= c_SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_an         <= w_an_nxt;
      r_cat        <= w_cat_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  // A load coinciding with the commit edge lands in the shadow and stays pending,
  // while the commit itself takes the previous shadow contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_frame_end && r_pending) begin
        r_disp <= r_shadow;
      end
      if (bus.disp_load) begin
        r_shadow  <= bus.disp_data;
        r_pending <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_seven_seg_an  = r_an;
  assign o_seven_seg_cat = r_cat;
  assign o_frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seven_seg_scan : scoreboard bench for the seven-segment scanner
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] an;
  logic [6:0] cat;
  logic       fd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(8)) bus ();

  seven_seg_scan #(
    .SCAN_DIV   (3),
    .NUM_DIGITS (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .o_seven_seg_an  (an),
    .o_seven_seg_cat (cat),
    .o_frame_done    (fd)
  );

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // t counts cycles since reset release; every 4th cycle is the blank gap,
  // the other three drive digit (t/4)%8, and a frame spans 32 cycles.
  function automatic logic [15:0] predict(input int t, input logic [31:0] d,
                                          input logic [7:0] en, input logic lzb);
    logic [7:0] a;
    logic [6:0] c;
    logic [31:0] upper;
    int dig;
    a = 8'hFF;
    c = 7'h7F;
    if ((t % 4) != 0) begin
      dig   = (t / 4) % 8;
      upper = d >> (4 * dig);
      if (en[dig] && !(lzb && dig != 0 && upper == 32'h0)) begin
        a = ~(8'h01 << dig);
        c = seg_tab[upper[3:0]];
      end
    end
    return {a, c, ((t % 32) == 31)};
  endfunction

  int          m_t;
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  logic        m_pending;
  logic [15:0] exp_q [$];
  logic [15:0] sb_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t       = 0;
      m_disp    = 32'h0;
      m_shadow  = 32'h0;
      m_pending = 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(predict(m_t, m_disp, bus.digit_en, bus.lzb_en));
      if ((m_t % 32) == 31 && m_pending) begin
        m_disp    = m_shadow;
        m_pending = 1'b0;
      end
      if (bus.disp_load) begin
        m_shadow  = bus.disp_data;
        m_pending = 1'b1;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out", {16'h0, an, cat, fd}, {16'h0, 8'hFF, 7'h7F, 1'b0});
    end else if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check("scan_out", {16'h0, an, cat, fd}, {16'h0, sb_exp});
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] v);
    bus.disp_data = v;
    bus.disp_load = 1'b1;
    @(negedge clk);
    bus.disp_load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((m_t % 32) != ph && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("phase_wait_timeout", 32'(k >= 100), 32'h0);
  endtask

  initial begin
    bus.disp_data = 32'h0;
    bus.disp_load = 1'b0;
    bus.digit_en  = 8'hFF;
    bus.lzb_en    = 1'b0;
    rst_n         = 1'b0;
    run(3);
    rst_n = 1'b1;

    run(5);
    load(32'h0000_0009);
    run(3 * 32);

    load(32'h89AB_CDEF);
    run(2 * 32);

    // Mid-frame load while digit 3 is being scanned
    wait_phase(13);
    load(32'h1111_1111);
    run(2 * 32);

    // Two loads in one frame, then a third exactly on the commit edge
    wait_phase(5);
    load(32'h0000_0001);
    wait_phase(10);
    load(32'h0000_0002);
    wait_phase(31);
    load(32'h0000_0003);
    run(3 * 32);

    bus.lzb_en = 1'b1;
    load(32'h0000_0120);
    run(2 * 32 + 4);
    load(32'h0000_0000);
    run(2 * 32 + 4);

    bus.lzb_en   = 1'b0;
    bus.digit_en = 8'h0F;
    load(32'h1234_5678);
    run(2 * 32);

    // Asynchronous reset in the middle of digit 1's slot
    wait_phase(6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_an", {24'h0, an}, {24'h0, 8'hFF});
    check("async_reset_cat", {25'h0, cat}, {25'h0, 7'h7F});
    check("async_reset_fd", {31'h0, fd}, 32'h0);
    run(2);
    rst_n = 1'b1;
    run(2 * 32 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
